id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low; clears all state while 0.
REQ-003 if_inst  input  32  instruction from fetch stage (0 = bubble/NOP).
REQ-004 if_pc  input  32  PC of if_inst.
REQ-005 if_exc  input  2  fetch exception code {address-error, fetch-fault}.
REQ-006 int  input  1  interrupt/exception flush request.
REQ-007 ex_load  input  1  instruction currently in EX is a load.
REQ-008 ex_wreg  input  1  instruction currently in EX writes a GPR.
REQ-009 ex_dst  input  5  destination GPR of EX instruction.
REQ-010 rs_data, rt_data  input  32 each  register-file read data for rs_addr/rt_addr.
REQ-011 rs_addr, rt_addr  output  5 each  inst[25:21], inst[20:16] of the held ID instruction.
REQ-012 delay  output  1  stall request to fetch; fetch holds PC and instruction while 1.
REQ-013 branch  output  1  control transfer taken this cycle.
REQ-014 J  output  1  taken transfer is J/JAL/JR/JALR class.
REQ-015 target  output  32  redirect address, valid when branch=1.
REQ-016 ex_inst, ex_pc  output  32 each  registered instruction/PC to EX.
REQ-017 ex_exc  output  2  registered exception code to EX.
REQ-018 ex_bd  output  1  registered flag: ex_inst sits in a branch delay slot.

Function
REQ-019 ID holding register (id_inst, id_pc, id_exc, id_bd) SHALL load if_inst/if_pc/if_exc each clock when delay=0 and int=0; hold when delay=1.
REQ-020 id_bd SHALL be set on load iff the previously held instruction was any branch/jump opcode (taken or not).
REQ-021 int=1 SHALL, on that edge, clear id_inst, ex_inst to 0, id_exc/ex_exc to 0, id_bd/ex_bd to 0, FSM to RUN; int has priority over stall.
REQ-022 Decode SHALL recognise: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001 with rt=00000 BLTZ / rt=00001 BGEZ, J 000010, JAL 000011, opcode 0 with funct 001000 JR / 001001 JALR.
REQ-023 uses_rt SHALL be 1 for opcode 0 R-type, BEQ, BNE, stores (101xxx); else 0.
REQ-024 Load-use hazard: ex_load=1, ex_dst!=0, ex_dst==rs_addr or (uses_rt and ex_dst==rt_addr).
REQ-025 Branch hazard: held instruction is conditional branch or JR/JALR, ex_wreg=1, ex_dst!=0, ex_dst matches a source it reads.
REQ-026 FSM states RUN, STALL; RUN->STALL on either hazard; STALL->RUN after exactly one cycle; hazard re-evaluated in RUN.
REQ-027 delay SHALL equal 1 combinationally in RUN when a hazard is present and 1 throughout STALL-caused hold; 0 otherwise.
REQ-028 While delay=1 the EX register SHALL receive a bubble (ex_inst=0, ex_exc=0, ex_bd=0); ex_pc SHALL take id_pc.
REQ-029 Otherwise EX register SHALL load id_inst, id_pc, id_exc, id_bd.
REQ-030 Comparisons: BEQ rs==rt, BNE rs!=rt, BLEZ rs signed<=0, BGTZ rs signed>0, BLTZ rs[31]=1, BGEZ rs[31]=0.
REQ-031 branch SHALL be 1 only when delay=0, int=0, and condition true or instruction is J/JAL/JR/JALR.
REQ-032 target: conditional = id_pc+4+(sign-extended imm16<<2), 32-bit wrap; J/JAL = {id_pc+4 [31:28], inst[25:0], 2'b00}; JR/JALR = rs_data.
REQ-033 Unrecognised opcodes SHALL produce branch=0, J=0 with no stall from REQ-025.

Reset
REQ-034 reset=0 SHALL immediately force id_inst, ex_inst, ex_pc, id_pc to 0, ex_exc/id_exc to 0, ex_bd/id_bd to 0, FSM to RUN; outputs delay=0, branch=0, J=0.
REQ-035 Reset asserted mid-STALL SHALL abandon the stall; first post-reset edge loads if_inst normally.

Verification
REQ-036 LW r5 in EX (ex_load=1, ex_dst=5), ID holds ADD r6,r5,r7 -> delay=1 one cycle, ex_inst=0 that edge, next edge ex_inst=ADD.
REQ-037 ID BEQ r1,r2,imm=0x0003 at id_pc=0xBFC00010, rs_data=rt_data=7, no hazard -> branch=1, J=0, target=0xBFC00020; following instruction gets ex_bd=1.
REQ-038 ID J index 0x0000100 at id_pc=0xBFC00000 -> branch=1, J=1, target=0xB0000400.
REQ-039 ID BNE r3,r0 with ex_wreg=1, ex_dst=3 -> delay=1, branch=0 that cycle; next cycle branch evaluated with updated rs_data.
REQ-040 int=1 concurrent with load-use stall -> next edge ex_inst=0, id_inst=0, delay=0, FSM RUN.
REQ-041 reset pulsed low during STALL -> all outputs zero asynchronously; after release if_inst=0x24080001 reaches ex_inst two edges later.

Source files
------------

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : id_stage_if
// Brief   : Fetch/EX/register-file signal bundle seen by the decode stage.
// Revision: 1.0
// ============================================================================
interface id_stage_if;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [1:0]  if_exc;
    logic        int_req;
    logic        ex_load;
    logic        ex_wreg;
    logic [4:0]  ex_dst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        delay;
    logic        branch;
    logic        J;
    logic [31:0] target;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [1:0]  ex_exc;
    logic        ex_bd;

    modport master (
        output if_inst, if_pc, if_exc, int_req, ex_load, ex_wreg, ex_dst, rs_data, rt_data,
        input  rs_addr, rt_addr, delay, branch, J, target, ex_inst, ex_pc, ex_exc, ex_bd
    );

    modport slave (
        input  if_inst, if_pc, if_exc, int_req, ex_load, ex_wreg, ex_dst, rs_data, rt_data,
        output rs_addr, rt_addr, delay, branch, J, target, ex_inst, ex_pc, ex_exc, ex_bd
    );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_stage
// Brief   : Decode stage: hazard stall, branch resolution, ID/EX registers.
// Revision: 1.0
// ============================================================================
module id_stage (
    input  wire logic clk,
    input  wire logic reset,
    id_stage_if.slave bus
);
    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_STALL    = 1'b1;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc;
    logic [1:0]  r_id_exc;
    logic        r_id_bd;
    logic [31:0] r_ex_inst;
    logic [31:0] r_ex_pc;
    logic [1:0]  r_ex_exc;
    logic        r_ex_bd;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic        w_is_beq, w_is_bne, w_is_blez, w_is_bgtz, w_is_bltz, w_is_bgez;
    logic        w_is_j, w_is_jal, w_is_jr, w_is_jalr;
    logic        w_is_cond, w_is_jclass, w_is_xfer, w_uses_rt;
    logic        w_dst_live, w_hit_rs, w_hit_rt;
    logic        w_load_hazard, w_branch_hazard, w_hazard;
    logic        w_delay, w_cond_true, w_branch;
    logic        w_rs_zero, w_rs_neg;
    logic [31:0] w_pc4;
    logic [31:0] w_target;

    assign w_opcode = r_id_inst[31:26];
    assign w_rs     = r_id_inst[25:21];
    assign w_rt     = r_id_inst[20:16];
    assign w_funct  = r_id_inst[5:0];
    assign w_imm    = r_id_inst[15:0];

    assign w_is_beq    = (w_opcode == OP_BEQ);
    assign w_is_bne    = (w_opcode == OP_BNE);
    assign w_is_blez   = (w_opcode == OP_BLEZ);
    assign w_is_bgtz   = (w_opcode == OP_BGTZ);
    assign w_is_bltz   = (w_opcode == OP_REGIMM) && (w_rt == RT_BLTZ);
    assign w_is_bgez   = (w_opcode == OP_REGIMM) && (w_rt == RT_BGEZ);
    assign w_is_j      = (w_opcode == OP_J);
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_jr     = (w_opcode == OP_SPECIAL) && (w_funct == FN_JR);
    assign w_is_jalr   = (w_opcode == OP_SPECIAL) && (w_funct == FN_JALR);
    assign w_is_cond   = w_is_beq | w_is_bne | w_is_blez | w_is_bgtz | w_is_bltz | w_is_bgez;
    assign w_is_jclass = w_is_j | w_is_jal | w_is_jr | w_is_jalr;
    assign w_is_xfer   = w_is_cond | w_is_jclass;
    assign w_uses_rt   = (w_opcode == OP_SPECIAL) | w_is_beq | w_is_bne | (w_opcode[5:3] == 3'b101);

    // Only BEQ/BNE read rt among transfers; other branches and JR/JALR read rs alone.
    assign w_dst_live      = (bus.ex_dst != 5'd0);
    assign w_hit_rs        = (bus.ex_dst == w_rs);
    assign w_hit_rt        = (bus.ex_dst == w_rt);
    assign w_load_hazard   = bus.ex_load & w_dst_live & (w_hit_rs | (w_uses_rt & w_hit_rt));
    assign w_branch_hazard = bus.ex_wreg & w_dst_live & (w_is_cond | w_is_jr | w_is_jalr)
                           & (w_hit_rs | ((w_is_beq | w_is_bne) & w_hit_rt));
    assign w_hazard        = w_load_hazard | w_branch_hazard;

    assign w_rs_zero   = (bus.rs_data == 32'd0);
    assign w_rs_neg    = bus.rs_data[31];
    assign w_cond_true = (w_is_beq  & (bus.rs_data == bus.rt_data))
                       | (w_is_bne  & (bus.rs_data != bus.rt_data))
                       | (w_is_blez & (w_rs_neg | w_rs_zero))
                       | (w_is_bgtz & ~w_rs_neg & ~w_rs_zero)
                       | (w_is_bltz & w_rs_neg)
                       | (w_is_bgez & ~w_rs_neg);
    assign w_branch    = ~w_delay & ~bus.int_req & (w_cond_true | w_is_jclass);

    assign w_pc4 = r_id_pc + 32'd4;

    always_comb begin
        w_target = w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};
        if (w_is_j | w_is_jal) begin
            w_target = {w_pc4[31:28], r_id_inst[25:0], 2'b00};
        end else if (w_is_jr | w_is_jalr) begin
            w_target = bus.rs_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The stall cycle itself never re-stalls: by then the producer has left EX.
    always_comb begin
        w_state_next = r_state;
        if (bus.int_req) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   w_state_next = w_hazard ? S_STALL : S_RUN;
                S_STALL: w_state_next = S_RUN;
                default: w_state_next = S_RUN;
            endcase
        end
    end

    always_comb begin
        w_delay = 1'b0;
        case (r_state)
            S_RUN:   w_delay = w_hazard;
            default: w_delay = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_inst <= 32'd0;
            r_id_pc   <= 32'd0;
            r_id_exc  <= 2'd0;
            r_id_bd   <= 1'b0;
            r_ex_inst <= 32'd0;
            r_ex_pc   <= 32'd0;
            r_ex_exc  <= 2'd0;
            r_ex_bd   <= 1'b0;
        end else if (bus.int_req) begin
            r_id_inst <= 32'd0;
            r_id_exc  <= 2'd0;
            r_id_bd   <= 1'b0;
            r_ex_inst <= 32'd0;
            r_ex_pc   <= r_id_pc;
            r_ex_exc  <= 2'd0;
            r_ex_bd   <= 1'b0;
        end else if (w_delay) begin
            r_ex_inst <= 32'd0;
            r_ex_pc   <= r_id_pc;
            r_ex_exc  <= 2'd0;
            r_ex_bd   <= 1'b0;
        end else begin
            r_id_inst <= bus.if_inst;
            r_id_pc   <= bus.if_pc;
            r_id_exc  <= bus.if_exc;
            r_id_bd   <= w_is_xfer;
            r_ex_inst <= r_id_inst;
            r_ex_pc   <= r_id_pc;
            r_ex_exc  <= r_id_exc;
            r_ex_bd   <= r_id_bd;
        end
    end

    assign bus.rs_addr = w_rs;
    assign bus.rt_addr = w_rt;
    assign bus.delay   = w_delay;
    assign bus.branch  = w_branch;
    assign bus.J       = w_branch & w_is_jclass;
    assign bus.target  = w_target;
    assign bus.ex_inst = r_ex_inst;
    assign bus.ex_pc   = r_ex_pc;
    assign bus.ex_exc  = r_ex_exc;
    assign bus.ex_bd   = r_ex_bd;
endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// Testbench for id_stage: directed vector table, corner sequences, and
// randomized traffic checked against an instruction-level reference model.
module tb_id_stage;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    id_stage_if bus();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_NONE, K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BLTZ, K_BGEZ,
                  K_J, K_JAL, K_JR, K_JALR} kind_t;

    function automatic kind_t kind_of(input logic [31:0] i);
        logic [5:0] op = i[31:26];
        case (op)
            6'd4: return K_BEQ;
            6'd5: return K_BNE;
            6'd6: return K_BLEZ;
            6'd7: return K_BGTZ;
            6'd2: return K_J;
            6'd3: return K_JAL;
            6'd1: return (i[20:16] == 5'd0) ? K_BLTZ : ((i[20:16] == 5'd1) ? K_BGEZ : K_NONE);
            6'd0: return (i[5:0] == 6'd8) ? K_JR : ((i[5:0] == 6'd9) ? K_JALR : K_NONE);
            default: return K_NONE;
        endcase
    endfunction

    function automatic bit is_jump(input kind_t k);
        return (k == K_J) || (k == K_JAL) || (k == K_JR) || (k == K_JALR);
    endfunction

    function automatic bit hazard_of(input logic [31:0] i, input bit ld, input bit wr,
                                     input logic [4:0] dst);
        kind_t      k       = kind_of(i);
        logic [5:0] op      = i[31:26];
        bit         rt_used = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) ||
                              (op >= 6'h28 && op <= 6'h2F);
        bit         rs_hit  = (dst == i[25:21]);
        bit         rt_hit  = (dst == i[20:16]);
        bit         reads   = (k != K_NONE) && (k != K_J) && (k != K_JAL);
        bit         lu      = ld && (dst != 5'd0) && (rs_hit || (rt_used && rt_hit));
        bit         br      = wr && (dst != 5'd0) && reads &&
                              (rs_hit || (((k == K_BEQ) || (k == K_BNE)) && rt_hit));
        return lu || br;
    endfunction

    function automatic bit cond_taken(input kind_t k, input logic [31:0] rs, input logic [31:0] rt);
        case (k)
            K_BEQ:   return rs == rt;
            K_BNE:   return rs != rt;
            K_BLEZ:  return $signed(rs) <= 0;
            K_BGTZ:  return $signed(rs) > 0;
            K_BLTZ:  return $signed(rs) < 0;
            K_BGEZ:  return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_target(input kind_t k, input logic [31:0] i,
                                                 input logic [31:0] pc, input logic [31:0] rs);
        logic [31:0] seq = pc + 32'd4;
        logic [31:0] idx = {6'd0, i[25:0]};
        int          off = $signed(i[15:0]) * 4;
        case (k)
            K_J, K_JAL:   return (seq & 32'hF000_0000) | (idx << 2);
            K_JR, K_JALR: return rs;
            default:      return seq + 32'(off);
        endcase
    endfunction

    logic [31:0] m_id_inst, m_id_pc, m_ex_inst, m_ex_pc;
    logic [1:0]  m_id_exc, m_ex_exc;
    bit          m_id_bd, m_ex_bd, m_stalled, m_idpc_ok, m_expc_ok;

    task automatic model_reset();
        m_id_inst = 0; m_id_pc = 0; m_id_exc = 0; m_id_bd = 0;
        m_ex_inst = 0; m_ex_pc = 0; m_ex_exc = 0; m_ex_bd = 0;
        m_stalled = 0; m_idpc_ok = 1; m_expc_ok = 1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs  = 5'($urandom_range(0, 3));
        logic [4:0]  rt  = 5'($urandom_range(0, 3));
        logic [15:0] imm = 16'($urandom);
        case ($urandom_range(0, 14))
            0:  return {6'd4, rs, rt, imm};
            1:  return {6'd5, rs, rt, imm};
            2:  return {6'd6, rs, 5'd0, imm};
            3:  return {6'd7, rs, 5'd0, imm};
            4:  return {6'd1, rs, 5'd0, imm};
            5:  return {6'd1, rs, 5'd1, imm};
            6:  return {6'd2, 26'($urandom)};
            7:  return {6'd3, 26'($urandom)};
            8:  return {6'd0, rs, 5'd0, 5'd0, 5'd0, 6'd8};
            9:  return {6'd0, rs, 5'd0, 5'd31, 5'd0, 6'd9};
            10: return {6'd0, rs, rt, 5'd6, 5'd0, 6'h20};
            11: return {6'd9, rs, rt, imm};
            12: return {6'h2B, rs, rt, imm};
            13: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- drive helpers ----------------
    task automatic quiet_ex();
        bus.ex_load = 1'b0; bus.ex_wreg = 1'b0; bus.ex_dst = 5'd0; bus.int_req = 1'b0;
    endtask

    task automatic load_id(input logic [31:0] inst, input logic [31:0] pc);
        bus.if_inst = inst; bus.if_pc = pc; bus.if_exc = 2'd0;
        quiet_ex();
        @(posedge clk); #1;
        bus.if_inst = 32'd0; bus.if_pc = pc + 32'd4;
    endtask

    typedef struct {
        logic [31:0] inst, pc, rsd, rtd;
        logic        ld, wr;
        logic [4:0]  dst;
        logic        e_delay, e_branch, e_j;
        logic [31:0] e_target;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] ADD_R6_R5_R7 = 32'h00A73020;
    localparam logic [31:0] ADDIU_R8     = 32'h24080001;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        kind_t       k;
        bit          hz, e_delay, e_taken, e_j;
        logic [31:0] rsd;

        bus.if_inst = 0; bus.if_pc = 0; bus.if_exc = 0;
        bus.rs_data = 0; bus.rt_data = 0;
        quiet_ex();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_inst", bus.ex_inst, 32'd0);
        chk("rst_ex_pc",   bus.ex_pc,   32'd0);
        chk("rst_ex_exc",  32'(bus.ex_exc), 32'd0);
        chk("rst_ex_bd",   32'(bus.ex_bd),  32'd0);
        chk("rst_delay",   32'(bus.delay),  32'd0);
        chk("rst_branch",  32'(bus.branch), 32'd0);
        chk("rst_J",       32'(bus.J),      32'd0);
        chk("rst_rs_addr", 32'(bus.rs_addr), 32'd0);
        reset = 1'b1;

        // Directed decode / hazard vectors
        vecs.push_back('{32'h10220003, 32'hBFC00010, 32'd7, 32'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hBFC00020});
        vecs.push_back('{32'h10220003, 32'hBFC00010, 32'd7, 32'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h14600004, 32'h00400000, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00400014});
        vecs.push_back('{32'h14600004, 32'h00400000, 32'd5, 32'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h18400010, 32'h00001000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00001044});
        vecs.push_back('{32'h18400010, 32'h00001000, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h1C400010, 32'h00001000, 32'h80000000, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h1C400010, 32'h00001000, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00001044});
        vecs.push_back('{32'h0480FFFF, 32'h00002000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00002000});
        vecs.push_back('{32'h0481FFFF, 32'h00002000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00002000});
        vecs.push_back('{32'h0481FFFF, 32'h00002000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h08000100, 32'hBFC00000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'hB0000400});
        vecs.push_back('{32'h0FFFFFFF, 32'hF0000000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC});
        vecs.push_back('{32'h03E00008, 32'h00000100, 32'h80001234, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h80001234});
        vecs.push_back('{32'h03E0F809, 32'h00000100, 32'h00400100, 32'd0, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h03E0F809, 32'h00000100, 32'h00400100, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h00400100});
        vecs.push_back('{ADD_R6_R5_R7, 32'h00000200, 32'd0, 32'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{ADD_R6_R5_R7, 32'h00000200, 32'd0, 32'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h24A80001, 32'h00000200, 32'd0, 32'd0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{ADD_R6_R5_R7, 32'h00000200, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{ADD_R6_R5_R7, 32'h00000200, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'hFC400000, 32'h00000200, 32'd0, 32'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h04420004, 32'h00000200, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h10220001, 32'hFFFFFFF8, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00000000});
        vecs.push_back('{32'hACA70000, 32'h00000300, 32'd0, 32'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h10220003, 32'h00000300, 32'd4, 32'd4, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{32'h18400010, 32'h00001000, 32'd0, 32'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 32'h00001044});

        foreach (vecs[n]) begin
            load_id(vecs[n].inst, vecs[n].pc);
            bus.rs_data = vecs[n].rsd; bus.rt_data = vecs[n].rtd;
            bus.ex_load = vecs[n].ld;  bus.ex_wreg = vecs[n].wr; bus.ex_dst = vecs[n].dst;
            #1;
            chk($sformatf("vec%0d_delay", n),  32'(bus.delay),  32'(vecs[n].e_delay));
            chk($sformatf("vec%0d_branch", n), 32'(bus.branch), 32'(vecs[n].e_branch));
            chk($sformatf("vec%0d_J", n),      32'(bus.J),      32'(vecs[n].e_j));
            chk($sformatf("vec%0d_rs_addr", n), 32'(bus.rs_addr), 32'(vecs[n].inst[25:21]));
            chk($sformatf("vec%0d_rt_addr", n), 32'(bus.rt_addr), 32'(vecs[n].inst[20:16]));
            if (vecs[n].e_branch) chk($sformatf("vec%0d_target", n), bus.target, vecs[n].e_target);
        end

        // Load-use stall: one bubble, then the ADD proceeds
        load_id(ADD_R6_R5_R7, 32'h00000400);
        bus.ex_load = 1'b1; bus.ex_dst = 5'd5;
        #1 chk("lu_delay_on", 32'(bus.delay), 32'd1);
        @(posedge clk); #1;
        chk("lu_bubble", bus.ex_inst, 32'd0);
        chk("lu_bubble_pc", bus.ex_pc, 32'h00000400);
        bus.ex_load = 1'b0;
        #1 chk("lu_delay_off", 32'(bus.delay), 32'd0);
        @(posedge clk); #1;
        chk("lu_ex_add", bus.ex_inst, ADD_R6_R5_R7);

        // Taken BEQ and its delay slot
        load_id(32'h10220003, 32'hBFC00010);
        bus.if_inst = ADDIU_R8; bus.if_pc = 32'hBFC00014;
        bus.rs_data = 32'd7; bus.rt_data = 32'd7;
        #1;
        chk("beq_branch", 32'(bus.branch), 32'd1);
        chk("beq_J", 32'(bus.J), 32'd0);
        chk("beq_target", bus.target, 32'hBFC00020);
        @(posedge clk); #1;
        chk("beq_ex_inst", bus.ex_inst, 32'h10220003);
        bus.if_inst = 32'd0;
        @(posedge clk); #1;
        chk("ds_ex_inst", bus.ex_inst, ADDIU_R8);
        chk("ds_ex_bd", 32'(bus.ex_bd), 32'd1);
        @(posedge clk); #1;
        chk("after_ds_ex_bd", 32'(bus.ex_bd), 32'd0);

        // Branch hazard: BNE waits one cycle, then resolves with fresh rs
        load_id(32'h14600004, 32'h00400000);
        bus.ex_wreg = 1'b1; bus.ex_dst = 5'd3; bus.rs_data = 32'd0; bus.rt_data = 32'd0;
        #1;
        chk("bne_delay", 32'(bus.delay), 32'd1);
        chk("bne_branch_held", 32'(bus.branch), 32'd0);
        @(posedge clk); #1;
        bus.ex_wreg = 1'b0; bus.rs_data = 32'd9;
        #1;
        chk("bne_delay_off", 32'(bus.delay), 32'd0);
        chk("bne_branch", 32'(bus.branch), 32'd1);
        chk("bne_target", bus.target, 32'h00400014);
        @(posedge clk); #1;
        chk("bne_ex_inst", bus.ex_inst, 32'h14600004);

        // Flush concurrent with a load-use stall
        load_id(ADD_R6_R5_R7, 32'h00000300);
        bus.ex_load = 1'b1; bus.ex_dst = 5'd5; bus.int_req = 1'b1;
        #1;
        chk("int_delay_comb", 32'(bus.delay), 32'd1);
        chk("int_branch", 32'(bus.branch), 32'd0);
        @(posedge clk); #1;
        bus.int_req = 1'b0;
        chk("int_ex_inst", bus.ex_inst, 32'd0);
        chk("int_id_rs", 32'(bus.rs_addr), 32'd0);
        chk("int_id_rt", 32'(bus.rt_addr), 32'd0);
        chk("int_delay", 32'(bus.delay), 32'd0);
        bus.if_inst = ADD_R6_R5_R7;
        @(posedge clk); #1;
        chk("int_restall", 32'(bus.delay), 32'd1);
        quiet_ex();
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a stall
        load_id(ADD_R6_R5_R7, 32'h00000100);
        bus.ex_load = 1'b1; bus.ex_dst = 5'd5;
        @(posedge clk); #1;
        chk("pre_rst_ex_pc", bus.ex_pc, 32'h00000100);
        #1 reset = 1'b0;
        #1;
        chk("arst_ex_inst", bus.ex_inst, 32'd0);
        chk("arst_ex_pc",   bus.ex_pc,   32'd0);
        chk("arst_delay",   32'(bus.delay),  32'd0);
        chk("arst_branch",  32'(bus.branch), 32'd0);
        chk("arst_J",       32'(bus.J),      32'd0);
        bus.if_inst = ADDIU_R8; bus.if_pc = 32'h00000500; bus.ex_load = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_id_rt", 32'(bus.rt_addr), 32'd8);
        bus.if_inst = 32'd0;
        @(posedge clk); #1;
        chk("post_rst_ex_inst", bus.ex_inst, ADDIU_R8);

        // Randomized traffic against the reference model
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            bus.if_inst = rand_inst();
            bus.if_pc   = $urandom & 32'hFFFF_FFFC;
            bus.if_exc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus.int_req = ($urandom_range(0, 15) == 0);
            bus.ex_load = ($urandom_range(0, 2) == 0);
            bus.ex_wreg = 1'($urandom_range(0, 1));
            bus.ex_dst  = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: rsd = 32'd0;
                1: rsd = 32'd1;
                2: rsd = 32'hFFFF_FFFF;
                3: rsd = 32'h8000_0000;
                default: rsd = $urandom;
            endcase
            bus.rs_data = rsd;
            bus.rt_data = ($urandom_range(0, 1) == 1) ? rsd : $urandom;
            #2;
            k       = kind_of(m_id_inst);
            hz      = hazard_of(m_id_inst, bus.ex_load, bus.ex_wreg, bus.ex_dst);
            e_delay = !m_stalled && hz;
            e_taken = !e_delay && !bus.int_req && (is_jump(k) || cond_taken(k, bus.rs_data, bus.rt_data));
            e_j     = e_taken && is_jump(k);
            chk("rnd_delay",   32'(bus.delay),   32'(e_delay));
            chk("rnd_branch",  32'(bus.branch),  32'(e_taken));
            chk("rnd_J",       32'(bus.J),       32'(e_j));
            chk("rnd_rs_addr", 32'(bus.rs_addr), 32'(m_id_inst[25:21]));
            if (e_taken && (m_idpc_ok || k == K_JR || k == K_JALR))
                chk("rnd_target", bus.target, model_target(k, m_id_inst, m_id_pc, bus.rs_data));
            @(posedge clk); #1;
            if (bus.int_req) begin
                m_ex_inst = 0; m_ex_exc = 0; m_ex_bd = 0; m_expc_ok = 0;
                m_id_inst = 0; m_id_exc = 0; m_id_bd = 0; m_idpc_ok = 0;
                m_stalled = 0;
            end else if (e_delay) begin
                m_ex_inst = 0; m_ex_exc = 0; m_ex_bd = 0;
                m_ex_pc = m_id_pc; m_expc_ok = m_idpc_ok;
                m_stalled = 1;
            end else begin
                m_ex_inst = m_id_inst; m_ex_exc = m_id_exc; m_ex_bd = m_id_bd;
                m_ex_pc = m_id_pc; m_expc_ok = m_idpc_ok;
                m_id_bd   = (k != K_NONE);
                m_id_inst = bus.if_inst; m_id_pc = bus.if_pc; m_id_exc = bus.if_exc;
                m_idpc_ok = 1;
                m_stalled = 0;
            end
            chk("rnd_ex_inst", bus.ex_inst, m_ex_inst);
            chk("rnd_ex_exc",  32'(bus.ex_exc), 32'(m_ex_exc));
            chk("rnd_ex_bd",   32'(bus.ex_bd),  32'(m_ex_bd));
            if (m_expc_ok) chk("rnd_ex_pc", bus.ex_pc, m_ex_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
